// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alu_pkg                                                    |
// | Brief   : ALUControl encodings, divide-sequencer state encoding and  |
// |           opcode classification helpers shared by the ALU blocks.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int CTRL_W = 5;

  // ALUControl encodings
  localparam logic [CTRL_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 5'b00010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 5'b00011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 5'b00100;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 5'b00101;
  localparam logic [CTRL_W-1:0] ALU_DIV  = 5'b00110;
  localparam logic [CTRL_W-1:0] ALU_DIVU = 5'b00111;
  localparam logic [CTRL_W-1:0] ALU_REM  = 5'b01000;
  localparam logic [CTRL_W-1:0] ALU_REMU = 5'b01001;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 5'b01010;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 5'b01011;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 5'b01100;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 5'b01101;

  // Divide sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } div_state_t;

  // True for any of the four divide-group operations
  function automatic logic is_div_op(input logic [CTRL_W-1:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  // True for the signed variants (operands are two's complement)
  function automatic logic is_signed_op(input logic [CTRL_W-1:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

  // True when the quotient (rather than the remainder) is returned
  function automatic logic is_quot_op(input logic [CTRL_W-1:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : div_step                                                    |
// | Brief  : One restoring-division iteration: shift {rem,quo} left by   |
// |          one, trial-subtract the divisor, keep it when non-negative. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  // The shifted remainder can briefly need one extra bit before the subtract
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;

  // Shift, compare against the divisor, and pick the restored or reduced value
  always_comb begin
    w_shift  = {rem, quo[XLEN-1]};
    w_ge     = (w_shift >= {1'b0, divisor});
    // When w_ge holds the true difference is below the divisor, so the low bits suffice
    w_diff   = w_shift[XLEN-1:0] - divisor;
    rem_next = w_ge ? w_diff : w_shift[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], w_ge};
  end

endmodule
`default_nettype wire

// File: rtl/alu_div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_div_sequencer                                           |
// | Brief  : Multi-cycle DIV/DIVU/REM/REMU sequencer beside the ALU.     |
// |          Bit-serial restoring divider, pipeline stall while busy,    |
// |          one-cycle result_valid pulse, flush and special cases.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module alu_div_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CTRL_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [CTRL_WIDTH-1:0] ALUControl,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic                  flush,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  result_valid,
  output logic [XLEN-1:0]       result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t            r_state;
  div_state_t            w_state_nx;
  logic [CNT_W-1:0]      r_count;
  logic [CTRL_WIDTH-1:0] r_op;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [XLEN-1:0]       r_rem;
  logic [XLEN-1:0]       r_quo;
  logic [XLEN-1:0]       r_div;
  logic [XLEN-1:0]       r_result;

  logic                  w_accept;
  logic                  w_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [XLEN-1:0]       w_abs_a;
  logic [XLEN-1:0]       w_abs_b;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic                  w_special;
  logic [XLEN-1:0]       w_special_res;
  logic [XLEN-1:0]       w_rem_nx;
  logic [XLEN-1:0]       w_quo_nx;
  logic [XLEN-1:0]       w_final;

  // Accept decode, operand magnitudes and special-case detection
  always_comb begin
    w_accept   = (r_state == S_IDLE) & req_valid & is_div_op(ALUControl) & !flush & !reset;
    w_signed   = is_signed_op(ALUControl);
    w_a_neg    = w_signed & op_a[XLEN-1];
    w_b_neg    = w_signed & op_b[XLEN-1];
    w_abs_a    = w_a_neg ? -op_a : op_a;
    w_abs_b    = w_b_neg ? -op_b : op_b;
    w_div_zero = (op_b == '0);
    w_ovf      = w_signed & (op_a == c_int_min) & (op_b == '1);
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_special_res = is_quot_op(ALUControl) ? '1 : op_a;
    end else begin
      w_special_res = is_quot_op(ALUControl) ? c_int_min : '0;
    end
  end

  div_step #(
    .XLEN     (XLEN)
  ) u_div_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_div),
    .rem_next (w_rem_nx),
    .quo_next (w_quo_nx)
  );

  // Sign fix applied to the outcome of the final iteration
  always_comb begin
    if (is_quot_op(r_op)) begin
      w_final = r_neg_q ? -w_quo_nx : w_quo_nx;
    end else begin
      w_final = r_neg_r ? -w_rem_nx : w_rem_nx;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = w_special ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          w_state_nx = S_IDLE;
        end else if (r_count == '0) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath, counter and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= ALUControl;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_rem   <= '0;
      r_quo   <= w_abs_a;
      r_div   <= w_abs_b;
      r_count <= c_cnt_last;
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if ((r_state == S_BUSY) && !flush) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      if (r_count == '0) begin
        r_result <= w_final;
      end else begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  // Handshake and result outputs; a flushed DONE cycle never reports valid
  always_comb begin
    req_ready    = (r_state == S_IDLE) & !reset;
    stall        = (r_state == S_BUSY) | w_accept;
    result_valid = (r_state == S_DONE) & !flush;
    result       = r_result;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_alu_div_sequencer                                        |
// | Brief  : Self-checking bench for alu_div_sequencer: directed cases,  |
// |          randomized divides against an arithmetic reference model,   |
// |          flush, reset, ignored opcodes and back-to-back requests.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_alu_div_sequencer;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_DIV  = 5'b00110;
  localparam logic [4:0] OP_DIVU = 5'b00111;
  localparam logic [4:0] OP_REM  = 5'b01000;
  localparam logic [4:0] OP_REMU = 5'b01001;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [4:0]  ALUControl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        req_ready;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_div_sequencer #(
    .XLEN         (32),
    .CTRL_WIDTH   (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .ALUControl   (ALUControl),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .req_ready    (req_ready),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  // Reference: plain integer division with the architectural special cases
  function automatic logic [31:0] model_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0) return ((op == OP_DIV) || (op == OP_DIVU)) ? 32'hFFFF_FFFF : a;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == OP_DIV) ? 32'h8000_0000 : 32'd0;
    case (op)
      OP_DIV:  return 32'($signed(a) / $signed(b));
      OP_REM:  return 32'($signed(a) % $signed(b));
      OP_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  // Cycles from the accept cycle to the result cycle
  function automatic int model_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic idle_inputs();
    req_valid  = 1'b0;
    ALUControl = OP_ADD;
    op_a       = 32'd0;
    op_b       = 32'd0;
    flush      = 1'b0;
  endtask

  // Waits for result_valid from the current negedge; returns cycles waited (0 = never seen)
  task automatic wait_result(input int budget, output int lat, output bit stall_ok);
    lat      = 0;
    stall_ok = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      if (result_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  // One complete divide: accept, latency, stall shape, result, pulse width, hold
  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
    int          lat;
    bit          stall_ok;
    logic [31:0] exp_res;
    int          exp_lat;
    exp_res = model_result(op, a, b);
    exp_lat = model_latency(op, a, b);
    @(negedge clk);
    req_valid = 1'b1; ALUControl = op; op_a = a; op_b = b;
    #1;
    n_tests++;
    if (stall !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: stall=%b req_ready=%b required 1/1", name, stall, req_ready);
    end
    @(negedge clk);
    idle_inputs();
    wait_result(40, lat, stall_ok);
    n_tests++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_tests++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h required %h (a=%h b=%h)", name, result, exp_res, a, b);
    end
    n_tests++;
    if (!stall_ok || stall !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stall shape: busy_ok=%b done stall=%b req_ready=%b required 1/0/0",
               name, stall_ok, stall, req_ready);
    end
    @(negedge clk);
    n_tests++;
    if (result_valid !== 1'b0 || req_ready !== 1'b1 || result !== exp_res) begin
      n_fail++;
      $display("FAIL %s after pulse: result_valid=%b req_ready=%b result=%h required 0/1/%h",
               name, result_valid, req_ready, result, exp_res);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0 || stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset hold: ready=%b stall=%b valid=%b result=%h required all 0",
               req_ready, stall, result_valid, result);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset release: ready=%b stall=%b valid=%b result=%h required 1/0/0/0",
               req_ready, stall, result_valid, result);
    end
  endtask

  task automatic test_directed();
    run_div(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_div(OP_REMU, 32'd100, 32'd7, "remu_100_7");
    run_div(OP_DIV,  -32'sd7, 32'd2, "div_m7_2");
    run_div(OP_REM,  -32'sd7, 32'd2, "rem_m7_2");
    run_div(OP_DIV,  32'd7, -32'sd2, "div_7_m2");
    run_div(OP_REM,  32'd7, -32'sd2, "rem_7_m2");
  endtask

  task automatic test_special();
    run_div(OP_DIVU, 32'd5, 32'd0, "divu_by_zero");
    run_div(OP_REM,  32'd5, 32'd0, "rem_by_zero");
    run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_div(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    run_div(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_overflow");
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 14; i++) begin
      op = OP_DIV + 5'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0;
        3:       b = -32'($urandom_range(1, 9));
        default: b = $urandom >> $urandom_range(4, 28);
      endcase
      run_div(op, a, b, "random");
    end
  endtask

  task automatic test_flush();
    int  lat;
    bit  stall_ok;
    bit  leaked;
    // Flush during BUSY cycle 10
    @(negedge clk);
    req_valid = 1'b1; ALUControl = OP_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: ready=%b stall=%b valid=%b required 1/0/0",
               req_ready, stall, result_valid);
    end
    leaked = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid !== 1'b0) leaked = 1'b1;
    end
    n_tests++;
    if (leaked) begin
      n_fail++;
      $display("FAIL flush_busy leak: result_valid seen=1 required 0");
    end
    // Flush on the result cycle masks result_valid
    @(negedge clk);
    req_valid = 1'b1; ALUControl = OP_DIVU; op_a = 32'd77; op_b = 32'd5;
    @(negedge clk);
    idle_inputs();
    wait_result(40, lat, stall_ok);
    flush = 1'b1;
    #1;
    n_tests++;
    if (lat != 33 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: latency=%0d valid=%b required 33/0", lat, result_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done after: ready=%b valid=%b required 1/0", req_ready, result_valid);
    end
    // Flush in IDLE blocks accept
    @(negedge clk);
    req_valid = 1'b1; ALUControl = OP_DIV; op_a = 32'd50; op_b = 32'd5; flush = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle stall: got %b required 0", stall);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle accept: ready=%b valid=%b required 1/0", req_ready, result_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit leaked;
    @(negedge clk);
    req_valid = 1'b1; ALUControl = OP_DIV; op_a = 32'hDEAD_BEEF; op_b = 32'd13;
    @(negedge clk);
    idle_inputs();
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b0 || stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b stall=%b valid=%b result=%h required all 0",
               req_ready, stall, result_valid, result);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid release: ready=%b stall=%b required 1/0", req_ready, stall);
    end
    leaked = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid !== 1'b0) leaked = 1'b1;
    end
    n_tests++;
    if (leaked) begin
      n_fail++;
      $display("FAIL reset_mid leak: result_valid seen=1 required 0");
    end
  endtask

  task automatic test_ignore();
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; ALUControl = OP_ADD; op_a = 32'd9; op_b = 32'd3;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_add stall: got %b required 0", stall);
    end
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (req_ready !== 1'b1 || result_valid !== 1'b0 || stall !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL ignore_add state: ready=%b valid=%b stall=%b required 1/0/0",
               req_ready, result_valid, stall);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit stall_ok;
    @(negedge clk);
    req_valid = 1'b1; ALUControl = OP_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    // Keep requesting with the second operand pair; it must wait for the IDLE slot
    op_a = 32'hFFFF_FFFF; op_b = 32'h10;
    wait_result(40, lat, stall_ok);
    n_tests++;
    if (lat != 33 || result !== 32'd14 || req_ready !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b first: latency=%0d result=%h ready=%b stall=%b required 33/0000000e/0/0",
               lat, result, req_ready, stall);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b second accept: ready=%b stall=%b required 1/1", req_ready, stall);
    end
    @(negedge clk);
    idle_inputs();
    wait_result(40, lat, stall_ok);
    n_tests++;
    if (lat != 33 || !stall_ok || result !== 32'h0FFF_FFFF) begin
      n_fail++;
      $display("FAIL b2b second: latency=%0d stall_ok=%b result=%h required 33/1/0fffffff",
               lat, stall_ok, result);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_random();
    test_flush();
    test_reset_mid();
    test_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
